// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch sequencer.
// Imported by the controller and its arbiter.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP,
        DONE
    } state_t;

    localparam logic OP_CLR = 1'b0;
    localparam logic OP_SET = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin arbiter.
// The pointer names the client that wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Priority passes to whichever client was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (update && (gnt != 2'b00)) begin
            ptr <= gnt[0];
        end
    end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Arbitrated pulse sequencer for one NOR-pair SR latch.
// S and R come from registers and are never high together.
module sr_latch_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] op,
    output logic [1:0] ack,
    output logic       err,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    output logic       busy
);

    localparam int MAXW = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW   = $clog2(MAXW + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          gnt_q, gnt_n;
    logic          op_q, op_n;
    logic          s_n, r_n, err_n, busy_n;
    logic [1:0]    ack_n;
    logic [1:0]    arb_gnt;
    logic          upd;
    logic          op_sel;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .update (upd),
        .gnt    (arb_gnt)
    );

    assign op_sel = arb_gnt[1] ? op[1] : op[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gnt_q <= 1'b0;
            op_q  <= OP_CLR;
            s     <= 1'b0;
            r     <= 1'b0;
            ack   <= 2'b00;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            gnt_q <= gnt_n;
            op_q  <= op_n;
            s     <= s_n;
            r     <= r_n;
            ack   <= ack_n;
            err   <= err_n;
            busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        gnt_n   = gnt_q;
        op_n    = op_q;
        s_n     = s;
        r_n     = r;
        ack_n   = 2'b00;
        err_n   = 1'b0;
        busy_n  = busy;
        upd     = 1'b0;
        unique case (state)
            IDLE: begin
                if (arb_gnt != 2'b00) begin
                    upd     = 1'b1;
                    gnt_n   = arb_gnt[1];
                    op_n    = op_sel;
                    s_n     = (op_sel == OP_SET);
                    r_n     = (op_sel == OP_CLR);
                    cnt_n   = CW'(PULSE_W - 1);
                    busy_n  = 1'b1;
                    state_n = PULSE;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    s_n     = 1'b0;
                    r_n     = 1'b0;
                    cnt_n   = CW'(GAP_W - 1);
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    ack_n   = gnt_q ? 2'b10 : 2'b01;
                    err_n   = (q_fb != op_q);
                    state_n = DONE;
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Bench for sr_latch_ctrl driving behavioural NOR-pair latches.
// Default-timing instance for directed cases, 3/2 instance for random.
module tb_sr_latch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] req_a, op_a, ack_a;
    logic       err_a, s_a, r_a, q_a, busy_a;
    logic [1:0] req_b, op_b, ack_b;
    logic       err_b, s_b, r_b, q_b, busy_b;
    logic       stuck;
    logic       lq_a = 1'b0;
    logic       lq_b = 1'b0;

    sr_latch_ctrl u_dut_a (
        .clk(clk), .rst(rst), .req(req_a), .op(op_a), .ack(ack_a),
        .err(err_a), .s(s_a), .r(r_a), .q_fb(q_a), .busy(busy_a)
    );

    sr_latch_ctrl #(.PULSE_W(3), .GAP_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .req(req_b), .op(op_b), .ack(ack_b),
        .err(err_b), .s(s_b), .r(r_b), .q_fb(q_b), .busy(busy_b)
    );

    // Latch models: set wins nothing, both-high never happens by design.
    always @(s_a, r_a) begin
        if (s_a) lq_a = 1'b1;
        else if (r_a) lq_a = 1'b0;
    end
    always @(s_b, r_b) begin
        if (s_b) lq_b = 1'b1;
        else if (r_b) lq_b = 1'b0;
    end
    assign q_a = stuck ? 1'b0 : lq_a;
    assign q_b = lq_b;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [1:0] ack;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    logic exp_b0[$];
    logic exp_b1[$];

    task automatic push_a(input logic [1:0] a, input logic e);
        exp_t x;
        x.ack = a;
        x.err = e;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("sr_excl_a", 32'(s_a & r_a), 32'd0);
        if (ack_a != 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexp_a", 32'(ack_a), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_a", 32'(ack_a), 32'(e.ack));
                chk("err_a", 32'(err_a), 32'(e.err));
            end
        end
    end

    task automatic wait_ack(input int idx, input int lim);
        int n = 0;
        while (!ack_a[idx] && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("ack_wait", 32'(ack_a[idx]), 32'd1);
        req_a[idx] = 1'b0;
    endtask

    bit   pend_b[2];
    bit   pend_at_last[2];
    bit   acked_now[2];
    int   last_cli = -1;
    int   n_req[2];
    int   n_ack[2];
    logic e_op;
    logic o;

    initial begin
        req_a = 2'b00; op_a = 2'b00;
        req_b = 2'b00; op_b = 2'b00;
        stuck = 1'b0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out", 32'({s_a, r_a, ack_a, err_a, busy_a}), 32'd0);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("idle", 32'({s_a, r_a, ack_a, err_a, busy_a}), 32'd0);
        end

        // single set on client 0
        req_a = 2'b01; op_a = 2'b01;
        push_a(2'b01, 1'b0);
        @(negedge clk); chk("t2_p1", 32'({s_a, r_a, busy_a}), 32'b101);
        @(negedge clk); chk("t2_p2", 32'({s_a, r_a, busy_a}), 32'b101);
        @(negedge clk); chk("t2_gap", 32'({s_a, r_a, busy_a, ack_a}), 32'b00100);
        @(negedge clk); chk("t2_ack", 32'(ack_a), 32'b01);
        chk("t2_q", 32'(q_a), 32'd1);
        req_a = 2'b00;
        @(negedge clk); chk("t2_done", 32'({busy_a, ack_a}), 32'd0);

        // contention with ptr=0
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        op_a = 2'b10; req_a = 2'b11;
        push_a(2'b01, 1'b0);
        push_a(2'b10, 1'b0);
        @(negedge clk); chk("t3_r", 32'({s_a, r_a}), 32'b01);
        wait_ack(0, 10); chk("t3_q0", 32'(q_a), 32'd0);
        wait_ack(1, 12); chk("t3_q1", 32'(q_a), 32'd1);
        @(negedge clk);

        // stuck feedback
        stuck = 1'b1;
        op_a = 2'b10; req_a = 2'b10;
        push_a(2'b10, 1'b1);
        wait_ack(1, 10);
        chk("t4_err", 32'(err_a), 32'd1);
        @(negedge clk); chk("t4_busy", 32'(busy_a), 32'd0);
        stuck = 1'b0;

        // reset during pulse, then ptr must be back on client 0
        op_a = 2'b01; req_a = 2'b01;
        @(negedge clk); chk("t5_pulse", 32'(s_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst", 32'({s_a, r_a, busy_a, ack_a}), 32'd0);
        rst = 1'b0;
        op_a = 2'b00; req_a = 2'b11;
        push_a(2'b01, 1'b0);
        push_a(2'b10, 1'b0);
        wait_ack(0, 12); chk("t5_q0", 32'(q_a), 32'd0);
        wait_ack(1, 12);
        repeat (3) @(negedge clk);
        chk("a_left", 32'(exp_q.size()), 32'd0);

        // random traffic on the 3/2 instance
        for (int cyc = 0; cyc < 260; cyc++) begin
            @(negedge clk);
            chk("sr_excl_b", 32'(s_b & r_b), 32'd0);
            chk("ack_b_onehot", 32'(ack_b == 2'b11), 32'd0);
            for (int i = 0; i < 2; i++) begin
                acked_now[i] = 1'b0;
                if (ack_b[i]) begin
                    acked_now[i] = 1'b1;
                    n_ack[i]++;
                    chk("ack_b_dup", 32'(pend_b[i]), 32'd1);
                    if (pend_b[i]) begin
                        if (i == 0) e_op = exp_b0.pop_front();
                        else        e_op = exp_b1.pop_front();
                        chk("err_b", 32'(err_b), 32'd0);
                        chk("q_b", 32'(q_b), 32'(e_op));
                        if (last_cli == i && pend_at_last[1-i])
                            chk("alt_b", 32'(i), 32'(1 - i));
                    end
                    pend_b[i]       = 1'b0;
                    req_b[i]        = 1'b0;
                    last_cli        = i;
                    pend_at_last[0] = pend_b[0];
                    pend_at_last[1] = pend_b[1];
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (cyc < 200 && !pend_b[i] && !acked_now[i] &&
                    $urandom_range(2) == 0) begin
                    o         = 1'($urandom_range(1));
                    op_b[i]   = o;
                    req_b[i]  = 1'b1;
                    pend_b[i] = 1'b1;
                    n_req[i]++;
                    if (i == 0) exp_b0.push_back(o);
                    else        exp_b1.push_back(o);
                end
            end
        end
        chk("b_pend0", 32'(pend_b[0]), 32'd0);
        chk("b_pend1", 32'(pend_b[1]), 32'd0);
        chk("b_cnt0", 32'(n_ack[0]), 32'(n_req[0]));
        chk("b_cnt1", 32'(n_ack[1]), 32'(n_req[1]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
